// File: rtl/mcpu_defs.sv
// Shared definitions for the MCPU ALU issue path: opcodes, FSM encoding and
// instruction field offsets ({opcode, rd, rs1, rs2}, MSB to LSB).
package mcpu_defs;

  localparam logic [1:0] CMD_AND = 2'd0;
  localparam logic [1:0] CMD_OR  = 2'd1;
  localparam logic [1:0] CMD_XOR = 2'd2;
  localparam logic [1:0] CMD_ADD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_t;

  // Field offsets scale with the register index width.
  localparam int RS2_LSB = 0;

  function automatic int rs1_lsb(input int addr_size);
    return addr_size;
  endfunction

  function automatic int rd_lsb(input int addr_size);
    return 2 * addr_size;
  endfunction

  function automatic int op_lsb(input int addr_size);
    return 3 * addr_size;
  endfunction

endpackage

// File: rtl/MCPU_Alu.sv
// Combinational MCPU ALU: AND/OR/XOR/ADD, OVERFLOW is the ADD carry-out.
module MCPU_Alu
  import mcpu_defs::*;
#(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 8
) (
  input  logic [CMD_SIZE-1:0]  opcode,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [WORD_SIZE-1:0] r2,
  output logic [WORD_SIZE-1:0] out,
  output logic                 OVERFLOW
);

  logic [WORD_SIZE:0] sum;

  assign sum = {1'b0, r1} + {1'b0, r2};

  always_comb begin
    out      = '0;
    OVERFLOW = 1'b0;
    case (opcode)
      CMD_SIZE'(CMD_AND): out = r1 & r2;
      CMD_SIZE'(CMD_OR):  out = r1 | r2;
      CMD_SIZE'(CMD_XOR): out = r1 ^ r2;
      CMD_SIZE'(CMD_ADD): begin
        out      = sum[WORD_SIZE-1:0];
        OVERFLOW = sum[WORD_SIZE];
      end
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/mcpu_regfile.sv
// Small flop-based register file: two operand read ports, one readback port,
// a load write port and an ALU writeback port that wins on address collision.
module mcpu_regfile #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] rs1_addr,
  output logic [WORD_SIZE-1:0] rs1_data,
  input  logic [ADDR_SIZE-1:0] rs2_addr,
  output logic [WORD_SIZE-1:0] rs2_data,
  input  logic [ADDR_SIZE-1:0] rb_addr,
  output logic [WORD_SIZE-1:0] rb_data,
  input  logic                 ld_en,
  input  logic [ADDR_SIZE-1:0] ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic                 wb_en,
  input  logic [ADDR_SIZE-1:0] wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data
);

  localparam int DEPTH = 2 ** ADDR_SIZE;

  logic [WORD_SIZE-1:0] regs [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this is a handful of flops, not a RAM macro, so every entry is reset.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (ld_en) regs[ld_addr] <= ld_data;
      // Last non-blocking assignment wins, giving writeback priority over a load.
      if (wb_en) regs[wb_addr] <= wb_data;
    end
  end

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign rb_data  = regs[rb_addr];

endmodule

// File: rtl/mcpu_alu_issue.sv
// Sequencing wrapper around an external combinational MCPU_Alu: accepts an
// instruction, issues registered operands, then writes the result back.
module mcpu_alu_issue
  import mcpu_defs::*;
#(
  parameter int CMD_SIZE   = 2,
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_SIZE  = 2,
  parameter int INSTR_SIZE = CMD_SIZE + 3 * ADDR_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [INSTR_SIZE-1:0] instr,
  input  logic                  ld_valid,
  input  logic [ADDR_SIZE-1:0]  ld_addr,
  input  logic [WORD_SIZE-1:0]  ld_data,
  input  logic [ADDR_SIZE-1:0]  rb_addr,
  output logic [WORD_SIZE-1:0]  rb_data,
  output logic [CMD_SIZE-1:0]   alu_opcode,
  output logic [WORD_SIZE-1:0]  alu_r1,
  output logic [WORD_SIZE-1:0]  alu_r2,
  input  logic [WORD_SIZE-1:0]  alu_out,
  input  logic                  alu_overflow,
  output logic                  done,
  output logic                  ovf_flag
);

  localparam int RS1_LSB = rs1_lsb(ADDR_SIZE);
  localparam int RD_LSB  = rd_lsb(ADDR_SIZE);
  localparam int OP_LSB  = op_lsb(ADDR_SIZE);

  logic [CMD_SIZE-1:0]  instr_op;
  logic [ADDR_SIZE-1:0] instr_rd;
  logic [ADDR_SIZE-1:0] instr_rs1;
  logic [ADDR_SIZE-1:0] instr_rs2;

  assign instr_op  = instr[OP_LSB  +: CMD_SIZE];
  assign instr_rd  = instr[RD_LSB  +: ADDR_SIZE];
  assign instr_rs1 = instr[RS1_LSB +: ADDR_SIZE];
  assign instr_rs2 = instr[RS2_LSB +: ADDR_SIZE];

  state_t               state_q;
  state_t               state_d;
  logic [ADDR_SIZE-1:0] rd_q;
  logic [WORD_SIZE-1:0] rs1_data;
  logic [WORD_SIZE-1:0] rs2_data;
  logic                 accept;

  assign accept = instr_valid && instr_ready;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A pending load takes the cycle; the instruction waits.
        instr_ready = !ld_valid && !reset;
        if (instr_valid && !ld_valid && !reset) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WB;
      ST_WB: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_q       <= '0;
      alu_opcode <= '0;
      alu_r1     <= '0;
      alu_r2     <= '0;
      ovf_flag   <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values.
      state_q <= state_d;
      if (accept) begin
        rd_q       <= instr_rd;
        alu_opcode <= instr_op;
        alu_r1     <= rs1_data;
        alu_r2     <= rs2_data;
      end
      if (done) ovf_flag <= (alu_opcode == CMD_SIZE'(CMD_ADD)) && alu_overflow;
    end
  end

  mcpu_regfile #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (instr_rs1),
    .rs1_data (rs1_data),
    .rs2_addr (instr_rs2),
    .rs2_data (rs2_data),
    .rb_addr  (rb_addr),
    .rb_data  (rb_data),
    .ld_en    (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .wb_en    (done),
    .wb_addr  (rd_q),
    .wb_data  (alu_out)
  );

endmodule
